pll_reset_ctrl: RTL and testbench



---
 rtl/pll_reset_ctrl_pkg.sv | 23 ++
 rtl/pll_reset_ctrl_if.sv | 22 ++
 rtl/pll_reset_ctrl_sync2.sv | 19 +
 rtl/pll_reset_ctrl.sv | 141 ++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_reset_pkg;

    localparam int RELOCK_CNT_W = 8;

    typedef enum logic [2:0] {
        S_PLLRST  = 3'd0,
        S_WAIT    = 3'd1,
        S_STABLE  = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4
    } pll_rst_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// PLL-side and domain-side signals of the reset sequencer; slave = sequencer, master = PLL/system side.
interface pll_reset_ctrl_if #(
    parameter int NUM_DOMAINS = 3
);
    logic                                    pll_locked;
    logic                                    soft_reset;
    logic                                    pll_rst;
    logic [NUM_DOMAINS-1:0]                  dom_rst_n;
    logic                                    ready;
    logic [pll_reset_pkg::RELOCK_CNT_W-1:0]  relock_count;
    logic [2:0]                              state_dbg;

    modport slave (
        input  pll_locked, soft_reset,
        output pll_rst, dom_rst_n, ready, relock_count, state_dbg
    );

    modport master (
        output pll_locked, soft_reset,
        input  pll_rst, dom_rst_n, ready, relock_count, state_dbg
    );
endinterface

// File: rtl/pll_reset_ctrl_sync2.sv
// Generic two-flop synchronizer, asynchronously reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulse PLL reset, qualify lock, release domain resets in order.
// Define PLL_RELOCK_COUNT_EN to build the saturating lock-loss counter.
module pll_reset_ctrl
    import pll_reset_pkg::*;
#(
    parameter int NUM_DOMAINS   = 3,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP   = 16
) (
    input  logic            refclk,
    input  logic            rst_n,
    pll_reset_ctrl_if.slave bus
);
    localparam int CNT_MAX = max4(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES,
                                  RELEASE_GAP * (NUM_DOMAINS + 1));
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST = CW'(NUM_DOMAINS * RELEASE_GAP - 1);

    pll_rst_state_t         state;
    logic [CW-1:0]          cnt;
    logic                   locked_s;
    logic                   pll_rst_q;
    logic [NUM_DOMAINS-1:0] dom_q;
    logic                   ready_q;
    logic                   lock_lost;
    logic                   restart;

    sync2 u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    // soft_reset overrides everything and keeps the counter pinned at 0 while high
    assign lock_lost = !locked_s && (state == S_RELEASE || state == S_RUN);
    assign restart   = bus.soft_reset || lock_lost;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PLLRST;
            cnt       <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
        end else if (restart) begin
            state     <= S_PLLRST;
            cnt       <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            unique case (state)
                S_PLLRST: begin
                    if (cnt == RST_LAST) begin
                        state     <= S_WAIT;
                        cnt       <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (locked_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        state     <= S_PLLRST;
                        cnt       <= '0;
                        pll_rst_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == STB_LAST) begin
                        state    <= S_RELEASE;
                        cnt      <= '0;
                        dom_q[0] <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    // bit k drops k*RELEASE_GAP cycles after bit 0; one extra gap before ready
                    if (cnt == REL_LAST) begin
                        state   <= S_RUN;
                        cnt     <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        for (int k = 1; k < NUM_DOMAINS; k++) begin
                            if (cnt == CW'(k * RELEASE_GAP - 1)) dom_q[k] <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state     <= S_PLLRST;
                    cnt       <= '0;
                    pll_rst_q <= 1'b1;
                    dom_q     <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.dom_rst_n = dom_q;
    assign bus.ready     = ready_q;
    assign bus.state_dbg = state;

`ifdef PLL_RELOCK_COUNT_EN
    logic [RELOCK_CNT_W-1:0] relock_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            relock_q <= '0;
        end else if (lock_lost && !bus.soft_reset && relock_q != '1) begin
            relock_q <= relock_q + 1'b1;
        end
    end

    assign bus.relock_count = relock_q;
`else
    assign bus.relock_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with shortened timing parameters.
module tb_pll_reset_ctrl;

`ifdef PLL_RELOCK_COUNT_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [7:0] exp_rc;

    pll_reset_ctrl_if #(.NUM_DOMAINS(3)) bus ();

    pll_reset_ctrl #(
        .NUM_DOMAINS   (3),
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .RELEASE_GAP   (2)
    ) dut (
        .refclk (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Leaves the caller on the negedge where rst_n rises (cycle index 0).
    task automatic do_reset(input logic lk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.pll_locked = lk;
        bus.soft_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rc = 8'd0;
    endtask

    task automatic wait_state(input logic [2:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.state_dbg == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_dom(input logic [2:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.dom_rst_n == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.soft_reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL reset_pll_rst: got %b want 1", bus.pll_rst); end
        n_cmp++; if (bus.dom_rst_n !== 3'b000) begin n_err++; $display("FAIL reset_dom: got %b want 000", bus.dom_rst_n); end
        n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        n_cmp++; if (bus.relock_count !== 8'd0) begin n_err++; $display("FAIL reset_relock: got %0d want 0", bus.relock_count); end
        n_cmp++; if (bus.state_dbg !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.state_dbg); end
    endtask

    task automatic test_clean_start;
        int hi;
        do_reset(1'b0);
        hi = 0;
        while (bus.pll_rst === 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        n_cmp++; if (hi !== 4) begin n_err++; $display("FAIL clean_pll_rst_len: got %0d want 4", hi); end
        repeat (10) @(negedge clk);
        bus.pll_locked = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 10) begin n_cmp++; if (bus.dom_rst_n !== 3'b000) begin n_err++; $display("FAIL clean_dom_10: got %b want 000", bus.dom_rst_n); end end
            if (i == 11) begin n_cmp++; if (bus.dom_rst_n !== 3'b001) begin n_err++; $display("FAIL clean_dom_11: got %b want 001", bus.dom_rst_n); end end
            if (i == 12) begin n_cmp++; if (bus.dom_rst_n !== 3'b001) begin n_err++; $display("FAIL clean_dom_12: got %b want 001", bus.dom_rst_n); end end
            if (i == 13) begin n_cmp++; if (bus.dom_rst_n !== 3'b011) begin n_err++; $display("FAIL clean_dom_13: got %b want 011", bus.dom_rst_n); end end
            if (i == 15) begin n_cmp++; if (bus.dom_rst_n !== 3'b111) begin n_err++; $display("FAIL clean_dom_15: got %b want 111", bus.dom_rst_n); end end
            if (i == 16) begin n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL clean_ready_16: got %b want 0", bus.ready); end end
            if (i == 17) begin n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL clean_ready_17: got %b want 1", bus.ready); end end
            if (i == 17) begin n_cmp++; if (bus.state_dbg !== 3'd4) begin n_err++; $display("FAIL clean_state_17: got %0d want 4", bus.state_dbg); end end
        end
        n_cmp++; if (bus.relock_count !== 8'd0) begin n_err++; $display("FAIL clean_relock: got %0d want 0", bus.relock_count); end
    endtask

    task automatic test_lock_timeout;
        bit seen_ready;
        do_reset(1'b0);
        seen_ready = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) seen_ready = 1'b1;
            if (i == 23 || i == 47) begin n_cmp++; if (bus.pll_rst !== 1'b0) begin n_err++; $display("FAIL timeout_low_%0d: got %b want 0", i, bus.pll_rst); end end
            if (i == 24 || i == 48) begin n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL timeout_repulse_%0d: got %b want 1", i, bus.pll_rst); end end
        end
        n_cmp++; if (seen_ready !== 1'b0) begin n_err++; $display("FAIL timeout_ready: got %b want 0", seen_ready); end
        n_cmp++; if (bus.relock_count !== 8'd0) begin n_err++; $display("FAIL timeout_relock: got %0d want 0", bus.relock_count); end
    endtask

    task automatic test_glitch;
        do_reset(1'b1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 10) begin n_cmp++; if (bus.state_dbg !== 3'd2) begin n_err++; $display("FAIL glitch_state_10: got %0d want 2", bus.state_dbg); end end
            if (i == 11) begin n_cmp++; if (bus.state_dbg !== 3'd1) begin n_err++; $display("FAIL glitch_state_11: got %0d want 1", bus.state_dbg); end end
            if (i == 11) begin n_cmp++; if (bus.dom_rst_n !== 3'b000) begin n_err++; $display("FAIL glitch_dom_11: got %b want 000", bus.dom_rst_n); end end
            if (i == 11) begin n_cmp++; if (bus.relock_count !== 8'd0) begin n_err++; $display("FAIL glitch_relock: got %0d want 0", bus.relock_count); end end
            if (i == 12) begin n_cmp++; if (bus.state_dbg !== 3'd2) begin n_err++; $display("FAIL glitch_state_12: got %0d want 2", bus.state_dbg); end end
            if (i == 19) begin n_cmp++; if (bus.dom_rst_n !== 3'b000) begin n_err++; $display("FAIL glitch_dom_19: got %b want 000", bus.dom_rst_n); end end
            if (i == 20) begin n_cmp++; if (bus.dom_rst_n !== 3'b001) begin n_err++; $display("FAIL glitch_dom_20: got %b want 001", bus.dom_rst_n); end end
            if (i == 8) bus.pll_locked = 1'b0;
            if (i == 9) bus.pll_locked = 1'b1;
        end
    endtask

    task automatic test_lock_loss_run;
        bit ok;
        bit all_ok;
        wait_state(3'd4, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL run_reach: got %b want 1", ok); end
        @(negedge clk);
        bus.pll_locked = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            if (j == 2) begin n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL loss_ready_early: got %b want 1", bus.ready); end end
            if (j == 3) begin
                exp_rc = RC_EN ? 8'd1 : 8'd0;
                n_cmp++; if (bus.dom_rst_n !== 3'b000) begin n_err++; $display("FAIL loss_dom: got %b want 000", bus.dom_rst_n); end
                n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL loss_ready: got %b want 0", bus.ready); end
                n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL loss_pll_rst: got %b want 1", bus.pll_rst); end
                n_cmp++; if (bus.state_dbg !== 3'd0) begin n_err++; $display("FAIL loss_state: got %0d want 0", bus.state_dbg); end
                n_cmp++; if (bus.relock_count !== exp_rc) begin n_err++; $display("FAIL loss_relock: got %0d want %0d", bus.relock_count, exp_rc); end
            end
        end
        bus.pll_locked = 1'b1;
        wait_state(3'd4, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL loss_reseq: got %b want 1", ok); end
        all_ok = 1'b1;
        for (int r = 0; r < 300; r++) begin
            @(negedge clk);
            bus.pll_locked = 1'b0;
            repeat (3) @(negedge clk);
            bus.pll_locked = 1'b1;
            wait_state(3'd4, ok);
            if (!ok) all_ok = 1'b0;
            if (RC_EN && exp_rc != 8'd255) exp_rc = exp_rc + 8'd1;
        end
        n_cmp++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL sat_reseq: got %b want 1", all_ok); end
        n_cmp++; if (bus.relock_count !== exp_rc) begin n_err++; $display("FAIL sat_relock: got %0d want %0d", bus.relock_count, exp_rc); end
    endtask

    task automatic test_soft_coincident;
        bit ok;
        @(negedge clk);
        bus.soft_reset = 1'b1;
        @(negedge clk);
        bus.soft_reset = 1'b0;
        n_cmp++; if (bus.state_dbg !== 3'd0) begin n_err++; $display("FAIL soft_run_state: got %0d want 0", bus.state_dbg); end
        n_cmp++; if (bus.relock_count !== exp_rc) begin n_err++; $display("FAIL soft_run_relock: got %0d want %0d", bus.relock_count, exp_rc); end
        wait_state(3'd3, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL soft_reach_release: got %b want 1", ok); end
        bus.pll_locked = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.state_dbg !== 3'd3) begin n_err++; $display("FAIL soft_still_release: got %0d want 3", bus.state_dbg); end
        bus.soft_reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.state_dbg !== 3'd0) begin n_err++; $display("FAIL soft_coinc_state: got %0d want 0", bus.state_dbg); end
        n_cmp++; if (bus.dom_rst_n !== 3'b000) begin n_err++; $display("FAIL soft_coinc_dom: got %b want 000", bus.dom_rst_n); end
        n_cmp++; if (bus.relock_count !== exp_rc) begin n_err++; $display("FAIL soft_coinc_relock: got %0d want %0d", bus.relock_count, exp_rc); end
        repeat (6) @(negedge clk);
        n_cmp++; if (bus.state_dbg !== 3'd0) begin n_err++; $display("FAIL soft_hold_state: got %0d want 0", bus.state_dbg); end
        bus.soft_reset = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 3) begin n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL soft_release_hi: got %b want 1", bus.pll_rst); end end
            if (j == 4) begin n_cmp++; if (bus.state_dbg !== 3'd1) begin n_err++; $display("FAIL soft_release_wait: got %0d want 1", bus.state_dbg); end end
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        bus.pll_locked = 1'b1;
        wait_dom(3'b011, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL async_reach: got %b want 1", ok); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL async_pll_rst: got %b want 1", bus.pll_rst); end
        n_cmp++; if (bus.dom_rst_n !== 3'b000) begin n_err++; $display("FAIL async_dom: got %b want 000", bus.dom_rst_n); end
        n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL async_ready: got %b want 0", bus.ready); end
        n_cmp++; if (bus.state_dbg !== 3'd0) begin n_err++; $display("FAIL async_state: got %0d want 0", bus.state_dbg); end
        n_cmp++; if (bus.relock_count !== 8'd0) begin n_err++; $display("FAIL async_relock: got %0d want 0", bus.relock_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_rc = 8'd0;
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.soft_reset = 1'b0;
        test_reset();
        test_clean_start();
        test_lock_timeout();
        test_glitch();
        test_lock_loss_run();
        test_soft_coincident();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
